// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - command-driven SPI master: 10-bit command frames out, 8-bit read responses in
module spi_master_ctrl #(
  parameter int RD_LAT = 2,
  parameter int GAP    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  // Shared counter for the turnaround wait and the inter-frame gap.
  localparam int               CNT_W    = 8;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_WAIT,
    S_RECV,
    S_END
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [9:0]       r_frame, w_frame_nxt;
  logic             r_is_rd, w_is_rd_nxt;
  logic [3:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_rx, w_rx_nxt;
  logic             w_mosi_nxt;
  logic             w_rsp_load;

  logic             r_ss_n;
  logic             r_mosi;
  logic             r_cmd_ready;
  logic             r_busy;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_data;

  assign SS_n      = r_ss_n;
  assign MOSI      = r_mosi;
  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

  // Next-state logic; MOSI is computed one cycle ahead so the pin comes straight from a flop.
  always_comb begin
    w_state_nxt   = r_state;
    w_frame_nxt   = r_frame;
    w_is_rd_nxt   = r_is_rd;
    w_bit_cnt_nxt = r_bit_cnt;
    w_cnt_nxt     = r_cnt;
    w_rx_nxt      = r_rx;
    w_mosi_nxt    = 1'b0;
    w_rsp_load    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_frame_nxt = {cmd_op, cmd_data};
          w_is_rd_nxt = (cmd_op == 2'b11);
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_state_nxt   = S_SHIFT;
        w_bit_cnt_nxt = 4'd0;
        w_mosi_nxt    = r_frame[9];
        w_frame_nxt   = {r_frame[8:0], 1'b0};
      end
      S_SHIFT: begin
        if (r_bit_cnt != 4'd9) begin
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          w_mosi_nxt    = r_frame[9];
          w_frame_nxt   = {r_frame[8:0], 1'b0};
        end else if (r_is_rd) begin
          if (RD_LAT == 0) begin
            w_state_nxt   = S_RECV;
            w_bit_cnt_nxt = 4'd0;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_state_nxt = S_END;
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        if (r_cnt == LAT_LAST) begin
          w_state_nxt   = S_RECV;
          w_bit_cnt_nxt = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RECV: begin
        w_rx_nxt = {r_rx[6:0], MISO};
        if (r_bit_cnt == 4'd7) begin
          w_state_nxt = S_END;
          w_cnt_nxt   = '0;
          w_rsp_load  = 1'b1;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
        end
      end
      S_END: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_frame   <= '0;
      r_is_rd   <= 1'b0;
      r_bit_cnt <= '0;
      r_cnt     <= '0;
      r_rx      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_frame   <= w_frame_nxt;
      r_is_rd   <= w_is_rd_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rx      <= w_rx_nxt;
    end
  end

  // Output registers decoded from the next state, so no input reaches a pin combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
    end else begin
      r_ss_n      <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_END);
      r_mosi      <= w_mosi_nxt;
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_rsp_valid <= w_rsp_load;
      if (w_rsp_load) begin
        r_rsp_data <= w_rx_nxt;
      end
    end
  end

endmodule
